// File: rtl/conv_host_mem.sv
// conv_host_mem: host-side memory responder and result checker for the CONV accelerator
module conv_host_mem #(
  parameter int DW        = 20,
  parameter int AW        = 12,
  parameter int IMG_DEPTH = 4096,
  parameter int L1_DEPTH  = 1024,
  parameter int TIMEOUT   = 100000000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          ld_we,
  input  logic [1:0]    ld_sel,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  output logic          ready,
  input  logic          busy,
  input  logic [AW-1:0] iaddr,
  output logic [DW-1:0] idata,
  input  logic          cwr,
  input  logic [AW-1:0] caddr_wr,
  input  logic [DW-1:0] cdata_wr,
  input  logic          crd,
  input  logic [AW-1:0] caddr_rd,
  output logic [DW-1:0] cdata_rd,
  input  logic [2:0]    csel,
  output logic          done,
  output logic          timeout,
  output logic          l0_written,
  output logic          l1_written,
  output logic [12:0]   err_l0,
  output logic [10:0]   err_l1
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int LW = $clog2(L1_DEPTH);

  typedef enum logic [2:0] {IDLE, ARM, RUN, CMP0, CMP1, DONE} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [AW:0]   idx_q, idx_d;
  logic          timeout_q, timeout_d;
  logic          l0w_q, l0w_d;
  logic          l1w_q, l1w_d;
  logic          mm0_q, mm0_d;
  logic          mm1_q, mm1_d;
  logic [12:0]   err0_q, err0_d;
  logic [10:0]   err1_q, err1_d;
  logic [DW-1:0] hold_q, hold_d;

  logic [DW-1:0] img_mem  [IMG_DEPTH];
  logic [DW-1:0] l0_mem   [IMG_DEPTH];
  logic [DW-1:0] exp0_mem [IMG_DEPTH];
  logic [DW-1:0] l1_mem   [L1_DEPTH];
  logic [DW-1:0] exp1_mem [L1_DEPTH];

  logic          idle_like, conv_acc, sel0, sel1, rd_hit, expired;
  logic [DW-1:0] rd_val;

  assign idle_like = state_q == IDLE || state_q == DONE;
  assign conv_acc  = cwr && (state_q == ARM || state_q == RUN);
  assign sel0      = csel == 3'b001;
  assign sel1      = csel == 3'b011;
  assign rd_hit    = crd && (sel0 || sel1);
  assign expired   = timer_q == TW'(TIMEOUT - 1);
  assign rd_val    = sel0 ? l0_mem[caddr_rd] : l1_mem[caddr_rd[LW-1:0]];

  assign ready      = state_q == ARM;
  assign done       = state_q == DONE;
  assign timeout    = timeout_q;
  assign l0_written = l0w_q;
  assign l1_written = l1w_q;
  assign err_l0     = err0_q;
  assign err_l1     = err1_q;
  assign idata      = state_q == RUN ? img_mem[iaddr] : '0;
  assign cdata_rd   = rd_hit ? rd_val : hold_q;

  // Sequencing: handshake, timeout watch, two-bank sweep with a registered compare stage
  always_comb begin
    state_d   = state_q;
    timer_d   = (state_q == ARM || state_q == RUN) ? timer_q + 1'b1 : timer_q;
    idx_d     = idx_q;
    timeout_d = timeout_q;
    l0w_d     = l0w_q | (conv_acc & sel0);
    l1w_d     = l1w_q | (conv_acc & sel1);
    mm0_d     = state_q == CMP0 && l0w_q && l0_mem[idx_q[AW-1:0]] != exp0_mem[idx_q[AW-1:0]];
    mm1_d     = state_q == CMP1 && idx_q < (AW+1)'(L1_DEPTH) && l1w_q &&
                l1_mem[idx_q[LW-1:0]] != exp1_mem[idx_q[LW-1:0]];
    err0_d    = err0_q + 13'(mm0_q & ~&err0_q);
    err1_d    = err1_q + 11'(mm1_q & ~&err1_q);
    hold_d    = rd_hit ? rd_val : hold_q;
    case (state_q)
      IDLE, DONE: if (start) begin
        state_d   = ARM;
        timer_d   = '0;
        timeout_d = 1'b0;
        l0w_d     = 1'b0;
        l1w_d     = 1'b0;
        err0_d    = '0;
        err1_d    = '0;
      end
      ARM: if (expired) begin
        state_d   = DONE;
        timeout_d = 1'b1;
      end else if (busy) state_d = RUN;
      RUN: if (!busy) begin
        state_d = CMP0;
        idx_d   = '0;
      end else if (expired) begin
        state_d   = DONE;
        timeout_d = 1'b1;
      end
      CMP0: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == (AW+1)'(IMG_DEPTH - 1)) begin
          state_d = CMP1;
          idx_d   = '0;
        end
      end
      CMP1: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == (AW+1)'(L1_DEPTH)) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      idx_q     <= '0;
      timeout_q <= 1'b0;
      l0w_q     <= 1'b0;
      l1w_q     <= 1'b0;
      mm0_q     <= 1'b0;
      mm1_q     <= 1'b0;
      err0_q    <= '0;
      err1_q    <= '0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      idx_q     <= idx_d;
      timeout_q <= timeout_d;
      l0w_q     <= l0w_d;
      l1w_q     <= l1w_d;
      mm0_q     <= mm0_d;
      mm1_q     <= mm1_d;
      err0_q    <= err0_d;
      err1_q    <= err1_d;
      hold_q    <= hold_d;
    end
  end

  // Memory writes: host preload while idle, CONV results while armed or running
  always_ff @(posedge clk) begin
    if (ld_we && idle_like && ld_sel == 2'b00) img_mem[ld_addr] <= ld_data;
    if (ld_we && idle_like && ld_sel == 2'b01) exp0_mem[ld_addr] <= ld_data;
    if (ld_we && idle_like && ld_sel == 2'b10) exp1_mem[ld_addr[LW-1:0]] <= ld_data;
    if (conv_acc && sel0) l0_mem[caddr_wr] <= cdata_wr;
    if (conv_acc && sel1) l1_mem[caddr_wr[LW-1:0]] <= cdata_wr;
  end
endmodule

// File: tb/tb_conv_host_mem.sv
// tb_conv_host_mem: randomized self-checking bench for conv_host_mem against an array model
module tb_conv_host_mem;
  localparam int DW = 20;
  localparam int AW = 12;
  localparam int TO = 6000;

  logic          clk = 1'b0;
  logic          reset, start, ld_we, busy, cwr, crd;
  logic [1:0]    ld_sel;
  logic [AW-1:0] ld_addr, iaddr, caddr_wr, caddr_rd;
  logic [DW-1:0] ld_data, cdata_wr, idata, cdata_rd;
  logic [2:0]    csel;
  logic          ready, done, timeout, l0_written, l1_written;
  logic [12:0]   err_l0;
  logic [10:0]   err_l1;

  always #5 clk = ~clk;

  conv_host_mem #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .ld_we(ld_we), .ld_sel(ld_sel),
    .ld_addr(ld_addr), .ld_data(ld_data), .ready(ready), .busy(busy),
    .iaddr(iaddr), .idata(idata), .cwr(cwr), .caddr_wr(caddr_wr),
    .cdata_wr(cdata_wr), .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd),
    .csel(csel), .done(done), .timeout(timeout), .l0_written(l0_written),
    .l1_written(l1_written), .err_l0(err_l0), .err_l1(err_l1)
  );

  logic [DW-1:0] img_m [4096];
  logic [DW-1:0] l0_m  [4096];
  logic [DW-1:0] e0_m  [4096];
  logic [DW-1:0] w0    [4096];
  logic [DW-1:0] l1_m  [1024];
  logic [DW-1:0] e1_m  [1024];
  logic [DW-1:0] w1    [1024];
  logic [DW-1:0] hold_m;
  bit idle_m, acc_m, run_m, l0f_m, l1f_m;
  int n_cmp, n_bad, n;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rd_exp();
    if (crd && csel == 3'b001) return l0_m[caddr_rd];
    if (crd && csel == 3'b011) return l1_m[caddr_rd[9:0]];
    return hold_m;
  endfunction

  function automatic logic [31:0] exp_err0();
    int c = 0;
    if (!l0f_m) return 0;
    for (int i = 0; i < 4096; i++) if (l0_m[i] !== e0_m[i]) c++;
    return c > 8191 ? 8191 : c;
  endfunction

  function automatic logic [31:0] exp_err1();
    int c = 0;
    if (!l1f_m) return 0;
    for (int i = 0; i < 1024; i++) if (l1_m[i] !== e1_m[i]) c++;
    return c > 2047 ? 2047 : c;
  endfunction

  // one clock: check combinational reads, take the edge, then apply the edge's effects to the model
  task automatic cyc();
    logic [DW-1:0] r;
    #2;
    r = rd_exp();
    check("cdata_rd", cdata_rd, r);
    check("idata", idata, run_m ? img_m[iaddr] : '0);
    @(posedge clk);
    #1;
    if (crd && (csel == 3'b001 || csel == 3'b011)) hold_m = r;
    if (idle_m && ld_we && ld_sel == 2'b00) img_m[ld_addr] = ld_data;
    if (idle_m && ld_we && ld_sel == 2'b01) e0_m[ld_addr] = ld_data;
    if (idle_m && ld_we && ld_sel == 2'b10) e1_m[ld_addr[9:0]] = ld_data;
    if (acc_m && cwr && csel == 3'b001) begin l0_m[caddr_wr] = cdata_wr; l0f_m = 1; end
    if (acc_m && cwr && csel == 3'b011) begin l1_m[caddr_wr[9:0]] = cdata_wr; l1f_m = 1; end
  endtask

  task automatic start_run();
    start = 1;
    cyc();
    start = 0;
    idle_m = 0;
    acc_m = 1;
    l0f_m = 0;
    l1f_m = 0;
  endtask

  task automatic finish_run(input string tag);
    cwr = 0;
    crd = 0;
    busy = 0;
    cyc();
    run_m = 0;
    acc_m = 0;
    n = 0;
    while (!done && n < 6000) begin cyc(); n++; end
    check({tag, "_cmp_cycles"}, n, 5121);
    check({tag, "_err_l0"}, err_l0, exp_err0());
    check({tag, "_err_l1"}, err_l1, exp_err1());
    check({tag, "_timeout"}, timeout, 0);
    idle_m = 1;
  endtask

  initial begin
    logic [2:0] cs_tab [6];
    cs_tab = '{3'b001, 3'b000, 3'b010, 3'b111, 3'b011, 3'b011};
    n_cmp = 0; n_bad = 0;
    reset = 1; start = 0; ld_we = 0; ld_sel = 0; ld_addr = 0; ld_data = 0; busy = 0;
    iaddr = 0; cwr = 0; caddr_wr = 0; cdata_wr = 0; crd = 0; caddr_rd = 0; csel = 0;
    hold_m = 0; idle_m = 0; acc_m = 0; run_m = 0; l0f_m = 0; l1f_m = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    #1;
    check("rst_ready", ready, 0);
    check("rst_done", done, 0);
    check("rst_timeout", timeout, 0);
    check("rst_l0w", l0_written, 0);
    check("rst_l1w", l1_written, 0);
    check("rst_err_l0", err_l0, 0);
    check("rst_err_l1", err_l1, 0);
    check("rst_cdata_rd", cdata_rd, 0);
    check("rst_idata", idata, 0);
    idle_m = 1;
    for (int i = 0; i < 4096; i++) w0[i] = DW'($urandom);
    for (int i = 0; i < 1024; i++) w1[i] = DW'($urandom);
    ld_we = 1;
    for (int a = 0; a < 4096; a++) begin
      ld_sel = 2'b00; ld_addr = AW'(a); ld_data = a == 5 ? 20'h12345 : DW'($urandom); cyc();
      ld_sel = 2'b01; ld_data = w0[a] ^ DW'(a == 100); cyc();
    end
    for (int a = 0; a < 1024; a++) begin
      ld_sel = 2'b10; ld_addr = {2'($urandom), 10'(a)}; ld_data = w1[a] ^ DW'(a == 3); cyc();
    end
    ld_we = 0;

    // run 1: handshake, full fill of both banks, one planted mismatch per bank
    start_run();
    #1;
    check("arm_ready", ready, 1);
    check("arm_done", done, 0);
    repeat (3) cyc();
    check("arm_ready_hold", ready, 1);
    busy = 1; iaddr = 5;
    cyc();
    run_m = 1;
    check("run_ready", ready, 0);
    check("run_idata5", idata, 20'h12345);
    ld_we = 1; ld_sel = 2'b00; ld_addr = 5; ld_data = 20'h0BEEF;
    cyc();
    ld_we = 0;
    cyc();
    cwr = 1;
    for (int a = 0; a < 4096; a++) begin
      csel = 3'b001; caddr_wr = AW'(a); cdata_wr = w0[a]; iaddr = AW'($urandom); cyc();
    end
    for (int a = 0; a < 1024; a++) begin
      csel = 3'b011; caddr_wr = {a == 255 ? 2'b01 : 2'($urandom), 10'(a)}; cdata_wr = w1[a]; cyc();
    end
    csel = 3'b000; caddr_wr = 100; cdata_wr = ~w0[100]; cyc();
    csel = 3'b111; caddr_wr = 3; cdata_wr = ~w1[3]; cyc();
    cwr = 0; crd = 1; csel = 3'b011; caddr_rd = 12'h0FF;
    #1;
    check("l1_rd_0ff", cdata_rd, w1[255]);
    cyc();
    finish_run("run1");
    check("run1_err_l0_one", err_l0, 1);
    check("run1_err_l1_one", err_l1, 1);
    check("run1_l0w", l0_written, 1);
    check("run1_l1w", l1_written, 1);

    // run 2: readback, read-before-write, random traffic without any L1 write
    start_run();
    #1;
    check("run2_clr_err_l0", err_l0, 0);
    check("run2_clr_l0w", l0_written, 0);
    check("run2_clr_done", done, 0);
    busy = 1;
    cyc();
    run_m = 1;
    cwr = 1; csel = 3'b001; caddr_wr = 12'h7FF; cdata_wr = 20'hABCDE;
    cyc();
    cwr = 0; crd = 1; caddr_rd = 12'h7FF;
    #1;
    check("rdback", cdata_rd, 20'hABCDE);
    cyc();
    crd = 0; caddr_rd = 0;
    #1;
    check("hold", cdata_rd, 20'hABCDE);
    cyc();
    cwr = 1; crd = 1; caddr_wr = 12'h7FF; caddr_rd = 12'h7FF; cdata_wr = 20'h11111;
    #1;
    check("raw_old", cdata_rd, 20'hABCDE);
    cyc();
    cwr = 0;
    #1;
    check("raw_new", cdata_rd, 20'h11111);
    cyc();
    csel = 3'b010; caddr_rd = 0;
    #1;
    check("bad_csel_hold", cdata_rd, 20'h11111);
    cyc();
    for (int i = 0; i < 300; i++) begin
      csel = cs_tab[$urandom_range(0, 5)];
      cwr = csel == 3'b011 ? 1'b0 : 1'($urandom);
      crd = 1'($urandom);
      caddr_wr = AW'($urandom); caddr_rd = AW'($urandom);
      cdata_wr = DW'($urandom); iaddr = AW'($urandom);
      cyc();
    end
    finish_run("run2");
    check("run2_err_l1_zero", err_l1, 0);
    check("run2_l1w", l1_written, 0);
    check("run2_l0w", l0_written, 1);

    // run 3: busy never falls, timer expires
    start_run();
    busy = 1;
    cyc();
    run_m = 1;
    n = 1;
    while (!done && n < TO + 10) begin cyc(); n++; end
    run_m = 0; acc_m = 0; idle_m = 1;
    check("to_cycles", n, TO);
    check("to_flag", timeout, 1);
    check("to_err_l0", err_l0, 0);
    check("to_err_l1", err_l1, 0);
    busy = 0;
    cyc();

    // run 4: reset during the sweep
    start_run();
    busy = 1;
    cyc();
    run_m = 1;
    busy = 0;
    cyc();
    run_m = 0; acc_m = 0;
    repeat (10) cyc();
    check("cmp0_done", done, 0);
    reset = 1;
    cyc();
    reset = 0; hold_m = 0; idle_m = 1;
    check("rst2_done", done, 0);
    check("rst2_ready", ready, 0);
    check("rst2_timeout", timeout, 0);
    check("rst2_err_l0", err_l0, 0);
    repeat (6000) cyc();
    check("rst2_idle_done", done, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
